// File: rtl/core_control_exc_entry_if.sv
// Bundles the exception-entry sequencer's bus: the detector and pipeline inputs,
// and the register-file, CPSR/SPSR and fetch-redirect outputs.
interface core_control_exc_entry_if;
  logic        exception;
  logic [4:0]  exception_mode;
  logic [31:0] exception_vector;
  logic        exception_offset_pc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] cpsr;
  logic        busy;
  logic        spsr_we;
  logic [31:0] spsr_value;
  logic        cpsr_we;
  logic [31:0] cpsr_value;
  logic        reg_we;
  logic [4:0]  reg_mode;
  logic [3:0]  reg_index;
  logic [31:0] reg_value;
  logic        branch;
  logic [31:0] branch_target;
  logic        flush;

  modport master (
    output exception, exception_mode, exception_vector, exception_offset_pc, stall, pc, cpsr,
    input  busy, spsr_we, spsr_value, cpsr_we, cpsr_value, reg_we, reg_mode, reg_index,
           reg_value, branch, branch_target, flush
  );

  modport slave (
    input  exception, exception_mode, exception_vector, exception_offset_pc, stall, pc, cpsr,
    output busy, spsr_we, spsr_value, cpsr_we, cpsr_value, reg_we, reg_mode, reg_index,
           reg_value, branch, branch_target, flush
  );
endinterface

// File: rtl/core_control_exc_entry.sv
// Exception entry sequencer: banks CPSR into SPSR, switches mode, writes the banked LR
// and redirects fetch to the vector, holding the pipeline busy throughout.
module core_control_exc_entry (
  input  logic                           clk,
  input  logic                           rst_n,
  core_control_exc_entry_if.slave        bus
);
  typedef enum logic [2:0] {IDLE, LATCH, SWITCH, LINK, BRANCH} state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] saved_pc_q, saved_pc_d;
  logic [31:0] saved_cpsr_q, saved_cpsr_d;
  logic [4:0]  mode_q, mode_d;
  logic [31:0] vector_q, vector_d;
  logic        offset_q, offset_d;

  logic [31:0] new_cpsr;
  logic [31:0] link_value;

  // FIQ entry also masks FIQ; every other mode keeps the old F bit.
  assign new_cpsr   = {saved_cpsr_q[31:8], 1'b1,
                       (mode_q == 5'b10001) ? 1'b1 : saved_cpsr_q[6], 1'b0, mode_q};
  assign link_value = saved_pc_q + (offset_q ? 32'd4 : 32'd8);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    saved_pc_d   = saved_pc_q;
    saved_cpsr_d = saved_cpsr_q;
    mode_d       = mode_q;
    vector_d     = vector_q;
    offset_d     = offset_q;

    bus.busy          = (state_q != IDLE);
    bus.spsr_we       = 1'b0;
    bus.spsr_value    = 32'd0;
    bus.cpsr_we       = 1'b0;
    bus.cpsr_value    = 32'd0;
    bus.reg_we        = 1'b0;
    bus.reg_mode      = 5'd0;
    bus.reg_index     = 4'd0;
    bus.reg_value     = 32'd0;
    bus.branch        = 1'b0;
    bus.branch_target = 32'd0;
    bus.flush         = 1'b0;

    // Requests arriving mid-sequence collapse into one chained entry.
    if (state_q != IDLE && bus.exception) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rst_n && bus.exception) begin
          bus.flush    = 1'b1;
          saved_pc_d   = bus.pc;
          saved_cpsr_d = bus.cpsr;
          state_d      = LATCH;
        end
      end
      LATCH: begin
        if (!bus.stall) begin
          mode_d   = bus.exception_mode;
          vector_d = bus.exception_vector;
          offset_d = bus.exception_offset_pc;
          state_d  = SWITCH;
        end
      end
      SWITCH: begin
        bus.spsr_value = saved_cpsr_q;
        bus.cpsr_value = new_cpsr;
        if (!bus.stall) begin
          bus.spsr_we = 1'b1;
          bus.cpsr_we = 1'b1;
          state_d     = LINK;
        end
      end
      LINK: begin
        bus.reg_mode  = mode_q;
        bus.reg_index = 4'd14;
        bus.reg_value = link_value;
        if (!bus.stall) begin
          bus.reg_we = 1'b1;
          state_d    = BRANCH;
        end
      end
      BRANCH: begin
        bus.branch_target = vector_q;
        if (!bus.stall) begin
          bus.branch = 1'b1;
          // A chained entry starts from the state the completed entry left behind.
          if (pending_q || bus.exception) begin
            pending_d    = 1'b0;
            saved_cpsr_d = new_cpsr;
            saved_pc_d   = vector_q;
            state_d      = LATCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      saved_pc_q   <= 32'd0;
      saved_cpsr_q <= 32'd0;
      mode_q       <= 5'd0;
      vector_q     <= 32'd0;
      offset_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      saved_pc_q   <= saved_pc_d;
      saved_cpsr_q <= saved_cpsr_d;
      mode_q       <= mode_d;
      vector_q     <= vector_d;
      offset_q     <= offset_d;
    end
  end
endmodule

// File: tb/tb_core_control_exc_entry.sv
// Directed bench for the exception entry sequencer: single entries, FIQ target,
// stall in LINK, chained entry, reset mid-sequence and LR wrap.
module tb_core_control_exc_entry;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   branch_cnt = 0;

  core_control_exc_entry_if bus();

  core_control_exc_entry dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.branch) branch_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_strobes"}, bus.spsr_we | bus.cpsr_we | bus.reg_we | bus.branch | bus.flush, 1'b0);
    chk({tag, "_values"}, bus.spsr_value | bus.cpsr_value | bus.reg_value | bus.branch_target
        | {23'd0, bus.reg_mode, bus.reg_index}, 32'd0);
  endtask

  // Full unstalled entry starting in IDLE; ends one cycle after BRANCH.
  task automatic run_entry(input string tag, input logic [31:0] pc_in, input logic [31:0] cpsr_in,
                           input logic [4:0] mode, input logic [31:0] vec, input logic off,
                           input logic [31:0] exp_cpsr, input logic [31:0] exp_lr);
    bus.exception = 1'b1;
    bus.pc        = pc_in;
    bus.cpsr      = cpsr_in;
    smp();
    chk1({tag, "_flush"}, bus.flush, 1'b1);
    chk1({tag, "_busy_idle"}, bus.busy, 1'b0);
    nxt();
    bus.exception           = 1'b0;
    bus.pc                  = 32'hDEADBEEF;
    bus.cpsr                = 32'hFFFFFFFF;
    bus.exception_mode      = mode;
    bus.exception_vector    = vec;
    bus.exception_offset_pc = off;
    smp();
    chk1({tag, "_busy_latch"}, bus.busy, 1'b1);
    chk1({tag, "_latch_quiet"}, bus.spsr_we | bus.cpsr_we | bus.reg_we | bus.branch, 1'b0);
    nxt();
    bus.exception_mode      = 5'd0;
    bus.exception_vector    = 32'h0BAD0BAD;
    bus.exception_offset_pc = ~off;
    smp();
    chk1({tag, "_spsr_we"}, bus.spsr_we, 1'b1);
    chk({tag, "_spsr_value"}, bus.spsr_value, cpsr_in);
    chk1({tag, "_cpsr_we"}, bus.cpsr_we, 1'b1);
    chk({tag, "_cpsr_value"}, bus.cpsr_value, exp_cpsr);
    nxt();
    smp();
    chk1({tag, "_reg_we"}, bus.reg_we, 1'b1);
    chk({tag, "_reg_mode"}, {27'd0, bus.reg_mode}, {27'd0, mode});
    chk({tag, "_reg_index"}, {28'd0, bus.reg_index}, 32'd14);
    chk({tag, "_lr"}, bus.reg_value, exp_lr);
    nxt();
    smp();
    chk1({tag, "_branch"}, bus.branch, 1'b1);
    chk({tag, "_target"}, bus.branch_target, vec);
    nxt();
    smp();
    chk1({tag, "_busy_after"}, bus.busy, 1'b0);
    chk1({tag, "_branch_after"}, bus.branch, 1'b0);
    nxt();
    $display("entry %s done: pc=%h cpsr=%h mode=%b vec=%h", tag, pc_in, cpsr_in, mode, vec);
  endtask

  initial begin
    rst_n                   = 1'b0;
    bus.exception           = 1'b0;
    bus.exception_mode      = 5'd0;
    bus.exception_vector    = 32'd0;
    bus.exception_offset_pc = 1'b0;
    bus.stall               = 1'b0;
    bus.pc                  = 32'd0;
    bus.cpsr                = 32'd0;
    #2;
    chk_all_zero("reset");
    $display("reset state checked");
    nxt();
    rst_n = 1'b1;
    nxt();

    run_entry("und", 32'h100, 32'h10, 5'b11011, 32'h4, 1'b1, 32'h9B, 32'h104);
    run_entry("dabt", 32'h2000, 32'h6000001F, 5'b10111, 32'hFFFF0010, 1'b0, 32'h60000097, 32'h2008);
    run_entry("fiq", 32'h300, 32'h13, 5'b10001, 32'h1C, 1'b1, 32'hD1, 32'h304);

    // Stall for three cycles in LINK.
    bus.exception = 1'b1;
    bus.pc        = 32'h400;
    bus.cpsr      = 32'h1F;
    nxt();
    bus.exception           = 1'b0;
    bus.exception_mode      = 5'b10011;
    bus.exception_vector    = 32'h8;
    bus.exception_offset_pc = 1'b1;
    nxt();
    smp();
    chk("stall_cpsr_value", bus.cpsr_value, 32'h93);
    nxt();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1("stall_reg_we_held", bus.reg_we, 1'b0);
      chk1("stall_busy", bus.busy, 1'b1);
      nxt();
    end
    bus.stall = 1'b0;
    smp();
    chk1("stall_reg_we_release", bus.reg_we, 1'b1);
    chk("stall_lr", bus.reg_value, 32'h404);
    nxt();
    smp();
    chk1("stall_reg_we_once", bus.reg_we, 1'b0);
    chk1("stall_branch", bus.branch, 1'b1);
    chk("stall_target", bus.branch_target, 32'h8);
    nxt();
    smp();
    chk1("stall_busy_after", bus.busy, 1'b0);
    nxt();
    $display("stall in LINK done");

    // Exception during SWITCH chains a second entry.
    branch_cnt    = 0;
    bus.exception = 1'b1;
    bus.pc        = 32'h500;
    bus.cpsr      = 32'h10;
    nxt();
    bus.exception           = 1'b0;
    bus.pc                  = 32'h777;
    bus.cpsr                = 32'hFFFFFFFF;
    bus.exception_mode      = 5'b11011;
    bus.exception_vector    = 32'h4;
    bus.exception_offset_pc = 1'b1;
    nxt();
    bus.exception           = 1'b1;
    bus.exception_mode      = 5'b10111;
    bus.exception_vector    = 32'h10;
    bus.exception_offset_pc = 1'b0;
    smp();
    chk("chain1_spsr", bus.spsr_value, 32'h10);
    chk("chain1_cpsr", bus.cpsr_value, 32'h9B);
    nxt();
    bus.exception = 1'b0;
    smp();
    chk("chain1_lr", bus.reg_value, 32'h504);
    chk("chain1_mode", {27'd0, bus.reg_mode}, 32'h1B);
    nxt();
    smp();
    chk1("chain1_branch", bus.branch, 1'b1);
    chk("chain1_target", bus.branch_target, 32'h4);
    nxt();
    smp();
    chk1("chain2_latch_busy", bus.busy, 1'b1);
    chk1("chain2_latch_quiet", bus.spsr_we | bus.cpsr_we | bus.reg_we | bus.branch, 1'b0);
    nxt();
    smp();
    chk1("chain2_spsr_we", bus.spsr_we, 1'b1);
    chk("chain2_spsr", bus.spsr_value, 32'h9B);
    chk("chain2_cpsr", bus.cpsr_value, 32'h97);
    nxt();
    smp();
    chk("chain2_lr", bus.reg_value, 32'hC);
    chk("chain2_mode", {27'd0, bus.reg_mode}, 32'h17);
    nxt();
    smp();
    chk1("chain2_branch", bus.branch, 1'b1);
    chk("chain2_target", bus.branch_target, 32'h10);
    nxt();
    smp();
    chk1("chain_busy_after", bus.busy, 1'b0);
    chk("chain_branch_count", branch_cnt, 32'd2);
    nxt();
    $display("chained entry done");

    // Reset asserted while in LINK.
    bus.exception = 1'b1;
    bus.pc        = 32'h600;
    bus.cpsr      = 32'h10;
    nxt();
    bus.exception           = 1'b0;
    bus.exception_mode      = 5'b10011;
    bus.exception_vector    = 32'h8;
    bus.exception_offset_pc = 1'b1;
    nxt();
    nxt();
    smp();
    chk1("rst_pre_reg_we", bus.reg_we, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_link");
    branch_cnt = 0;
    nxt();
    nxt();
    chk("rst_no_branch", branch_cnt, 32'd0);
    rst_n = 1'b1;
    nxt();
    $display("reset during LINK done");
    run_entry("post_rst", 32'h700, 32'h10, 5'b10011, 32'h8, 1'b1, 32'h93, 32'h704);

    run_entry("wrap", 32'hFFFFFFFC, 32'h10, 5'b10011, 32'h8, 1'b0, 32'h93, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_control_exc_entry.md
Name: core_control_exc_entry

Overview:
- Exception entry sequencer in the core control path, directly downstream of the exception detector.
- Consumes the detector's exception strobe and its registered target mode, vector and PC-offset select.
- Runs the architectural entry sequence: bank the old CPSR into the new mode's SPSR, switch CPSR, write the banked LR, then redirect fetch to the vector.
- Holds the pipeline busy for the whole sequence.

Parameters:
- none (data path fixed at 32 bits; mode field fixed at 5 bits)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- exception  in  1  exception request strobe from the detector, combinational and same cycle as the cause
- exception_mode  in  5  target mode; registered by the detector, valid the cycle after exception
- exception_vector  in  32  vector address; same timing as exception_mode
- exception_offset_pc  in  1  1: LR = pc+4; 0: LR = pc+8; same timing as exception_mode
- stall  in  1  freeze the FSM (register file or fetch busy)
- pc  in  32  address of the instruction being excepted; sampled with exception
- cpsr  in  32  current CPSR; sampled with exception
- busy  out  1  sequence in progress; upstream issue must hold
- spsr_we  out  1  write SPSR of cpsr_mode
- spsr_value  out  32  saved CPSR
- cpsr_we  out  1  write CPSR
- cpsr_value  out  32  new CPSR
- reg_we  out  1  banked GPR write strobe
- reg_mode  out  5  bank selector for the GPR write
- reg_index  out  4  GPR index, always 14
- reg_value  out  32  LR value
- branch  out  1  one-cycle fetch redirect strobe
- branch_target  out  32  redirect address
- flush  out  1  discard younger in-flight instructions

Behaviour:
- States: IDLE, LATCH, SWITCH, LINK, BRANCH.
- Reset (async, rst_n=0):
  - State goes to IDLE; pending and all latched registers clear to 0.
  - All outputs are 0.
  - Reset mid-sequence aborts immediately with no further strobes.
- IDLE:
  - On exception=1: capture pc into saved_pc and cpsr into saved_cpsr, go to LATCH.
  - flush=1 combinationally in that same cycle.
  - stall is ignored in IDLE.
- LATCH:
  - Capture exception_mode, exception_vector and exception_offset_pc. This is the first cycle these are valid.
  - Go to SWITCH.
- SWITCH:
  - spsr_we=1, spsr_value=saved_cpsr.
  - cpsr_we=1, cpsr_value = {saved_cpsr[31:8], 1'b1 (I), F', 1'b0 (T), mode}, where F' = 1 if mode==FIQ (10001) else saved_cpsr[6].
  - Go to LINK.
- LINK:
  - reg_we=1, reg_mode=latched mode, reg_index=14.
  - reg_value = saved_pc + (offset ? 4 : 8), modulo 2^32 (wraps silently).
  - Go to BRANCH.
- BRANCH:
  - branch=1, branch_target=latched vector.
  - If pending is set: clear it, go to LATCH. Otherwise go to IDLE.
- busy = (state != IDLE). Strobes are combinational decodes of the state; every strobe is 0 in IDLE and LATCH.
- Stall:
  - In any non-IDLE state, stall=1 holds the state and gates all write and branch strobes to 0.
  - The strobes reappear when stall drops.
  - Each strobe therefore fires exactly once per entry.
- Exception while busy:
  - Sets pending (a single bit; further requests merge into it).
  - Latched pc and cpsr are NOT overwritten.
  - The chained entry re-enters LATCH and takes mode and vector from the detector, which holds the highest-priority values.
  - For the chained entry, saved_cpsr is replaced by cpsr_value of the completed entry and saved_pc by the first entry's vector.
- Latency:
  - exception in IDLE to branch strobe = 4 cycles without stall.
  - busy is 0 again on the cycle after BRANCH.

Test Plan:
- Undefined entry: cpsr=0x00000010, pc=0x100, mode=11011, vector=0x00000004, offset=1 -> spsr_value=0x10, cpsr_value=0x0000009B, LR=0x104 in bank 11011, branch to 0x4 exactly 4 cycles after exception.
- Data abort with high vectors: cpsr=0x6000001F, pc=0x2000, mode=10111, vector=0xFFFF0010, offset=0 -> cpsr_value=0x60000097, LR=0x2008, branch_target=0xFFFF0010.
- FIQ-mode target: cpsr=0x13, mode=10001 -> cpsr_value=0x000000D1 (F set).
- Stall for 3 cycles in LINK -> reg_we=0 while stalled, asserted exactly once after release, branch 3 cycles late.
- Exception pulse during SWITCH, mode changes to 10111 -> first sequence completes, then LATCH/SWITCH/LINK/BRANCH repeat with saved_cpsr equal to the first cpsr_value; two branch strobes total.
- rst_n low during LINK -> all outputs 0 immediately, busy=0; an exception after release runs a clean full sequence.
- Wrap: pc=0xFFFFFFFC, offset=0 -> LR=0x00000004.
